// File: rtl/c4_pkg.sv
// Shared Connect-4 types: board geometry, cell encoding, board layout and the
// move-engine FSM states. Imported by the move engine and the win detector.
package c4_pkg;

  localparam int unsigned ROWS  = 6;
  localparam int unsigned COLS  = 7;
  localparam int unsigned CELLS = ROWS * COLS;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    P2    = 2'b10
  } cell_t;

  // Row 0 is the top of the board, row ROWS-1 the bottom.
  typedef cell_t [ROWS-1:0][COLS-1:0] board_t;
  typedef cell_t [ROWS-1:0]           column_t;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    PLACE,
    CHECK,
    REJECT,
    OVER
  } state_t;

  function automatic cell_t other_player(input cell_t p);
    return (p == P1) ? P2 : P1;
  endfunction

endpackage

// File: rtl/c4_move_engine_if.sv
// Board interface between the move engine (slave side) and the requester /
// win detector (master side).
interface c4_move_engine_if;
  import c4_pkg::*;

  logic        new_game;
  logic        move_valid;
  logic        move_ready;
  logic [2:0]  move_col;
  board_t      board;
  logic [2:0]  last_move_row;
  logic [2:0]  last_move_col;
  logic [1:0]  last_player;
  logic        win_in;
  logic [1:0]  cur_player;
  logic        move_done;
  logic        move_invalid;
  logic        game_over;
  logic [1:0]  winner;

  modport master (
    output new_game, move_valid, move_col, win_in,
    input  move_ready, board, last_move_row, last_move_col, last_player,
           cur_player, move_done, move_invalid, game_over, winner
  );

  modport slave (
    input  new_game, move_valid, move_col, win_in,
    output move_ready, board, last_move_row, last_move_col, last_player,
           cur_player, move_done, move_invalid, game_over, winner
  );

endinterface

// File: rtl/c4_move_engine_drop.sv
// c4_drop_finder: lowest empty row of one board column (priority towards the
// bottom row) and a column-full flag.
module c4_drop_finder
  import c4_pkg::*;
(
  input  column_t    col_i,
  output logic [2:0] lowest_empty_row_o,
  output logic       col_full_o
);

  // Later iterations are lower on the board, so the bottom-most empty cell wins.
  always_comb begin
    lowest_empty_row_o = '0;
    col_full_o         = 1'b1;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (col_i[r] == EMPTY) begin
        lowest_empty_row_o = 3'(r);
        col_full_o         = 1'b0;
      end
    end
  end

endmodule

// File: rtl/c4_move_engine.sv
// Connect-4 move engine: gravity drop, placement, verdict sampling, turn and
// game-over tracking. Define FAST_DROP_EN for a single-cycle column scan.
module c4_move_engine
  import c4_pkg::*;
#(
  parameter logic [1:0] FIRST_PLAYER = 2'd1
) (
  input  logic              clk,
  input  logic              rst_n,
  c4_move_engine_if.slave   bus
);

  state_t     state_q, state_d;
  logic [2:0] col_q, col_d;
  logic [2:0] row_q, row_d;
  board_t     board_q, board_d;
  logic [2:0] last_row_q, last_row_d;
  logic [2:0] last_col_q, last_col_d;
  cell_t      last_player_q, last_player_d;
  cell_t      cur_player_q, cur_player_d;
  logic [5:0] count_q, count_d;
  logic       game_over_q, game_over_d;
  cell_t      winner_q, winner_d;

  column_t    col_cells;
  logic [2:0] lowest_row;
  logic       col_full;

  always_comb begin
    for (int unsigned r = 0; r < ROWS; r++) begin
      col_cells[r] = board_q[r][col_q];
    end
  end

  c4_drop_finder u_drop (
    .col_i              (col_cells),
    .lowest_empty_row_o (lowest_row),
    .col_full_o         (col_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      col_q         <= '0;
      row_q         <= '0;
      board_q       <= board_t'('0);
      last_row_q    <= '0;
      last_col_q    <= '0;
      last_player_q <= EMPTY;
      cur_player_q  <= cell_t'(FIRST_PLAYER);
      count_q       <= '0;
      game_over_q   <= 1'b0;
      winner_q      <= EMPTY;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      board_q       <= board_d;
      last_row_q    <= last_row_d;
      last_col_q    <= last_col_d;
      last_player_q <= last_player_d;
      cur_player_q  <= cur_player_d;
      count_q       <= count_d;
      game_over_q   <= game_over_d;
      winner_q      <= winner_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    board_d       = board_q;
    last_row_d    = last_row_q;
    last_col_d    = last_col_q;
    last_player_d = last_player_q;
    cur_player_d  = cur_player_q;
    count_d       = count_q;
    game_over_d   = game_over_q;
    winner_d      = winner_q;

    if (bus.new_game) begin
      state_d       = IDLE;
      col_d         = '0;
      row_d         = '0;
      board_d       = board_t'('0);
      last_row_d    = '0;
      last_col_d    = '0;
      last_player_d = EMPTY;
      cur_player_d  = cell_t'(FIRST_PLAYER);
      count_d       = '0;
      game_over_d   = 1'b0;
      winner_d      = EMPTY;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.move_valid) begin
            if (bus.move_col >= 3'(COLS)) begin
              state_d = REJECT;
            end else begin
              col_d   = bus.move_col;
              row_d   = 3'(ROWS - 1);
              state_d = SCAN;
            end
          end
        end
        SCAN: begin
`ifdef FAST_DROP_EN
          if (col_full) begin
            state_d = REJECT;
          end else begin
            row_d   = lowest_row;
            state_d = PLACE;
          end
`else
          // Gravity keeps columns contiguous, so the first empty cell met on the
          // bottom-up walk is exactly the finder's lowest empty row.
          if (!col_full && (row_q == lowest_row)) begin
            state_d = PLACE;
          end else if (row_q == '0) begin
            state_d = REJECT;
          end else begin
            row_d = row_q - 3'd1;
          end
`endif
        end
        PLACE: begin
          board_d[row_q][col_q] = cur_player_q;
          last_row_d            = row_q;
          last_col_d            = col_q;
          last_player_d         = cur_player_q;
          if (count_q != 6'(CELLS)) begin
            count_d = count_q + 6'd1;
          end
          state_d = CHECK;
        end
        CHECK: begin
          if (bus.win_in) begin
            game_over_d = 1'b1;
            winner_d    = last_player_q;
            state_d     = OVER;
          end else if (count_q == 6'(CELLS)) begin
            game_over_d = 1'b1;
            winner_d    = EMPTY;
            state_d     = OVER;
          end else begin
            cur_player_d = other_player(cur_player_q);
            state_d      = IDLE;
          end
        end
        REJECT:  state_d = IDLE;
        OVER:    state_d = OVER;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.move_ready   = (state_q == IDLE);
    bus.move_done    = (state_q == CHECK);
    bus.move_invalid = (state_q == REJECT);
  end

  assign bus.board         = board_q;
  assign bus.last_move_row = last_row_q;
  assign bus.last_move_col = last_col_q;
  assign bus.last_player   = last_player_q;
  assign bus.cur_player    = cur_player_q;
  assign bus.game_over     = game_over_q;
  assign bus.winner        = winner_q;

endmodule

// File: tb/tb_c4_move_engine.sv
// Self-checking bench for c4_move_engine: directed game scenarios plus a
// randomized phase, all checked every cycle against a board-level game model.
module tb_c4_move_engine;
  import c4_pkg::*;

`ifdef FAST_DROP_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  c4_move_engine_if bus ();

  c4_move_engine #(.FIRST_PLAYER(2'd1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- game model ----------------
  int mb [ROWS][COLS];
  int mcur = 1, mlr = 0, mlc = 0, mlp = 0, mover = 0, mwin = 0, mcnt = 0;
  int idle_from = 0, ev_kind = 0, ev_cyc = 0, ev_row = 0, ev_col = 0;

  function automatic void model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) mb[r][c] = 0;
    mcur = 1; mlr = 0; mlc = 0; mlp = 0; mover = 0; mwin = 0; mcnt = 0;
    ev_kind = 0;
  endfunction

  function automatic logic [ROWS*COLS*2-1:0] exp_board();
    logic [ROWS*COLS*2-1:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) v[(r*COLS+c)*2 +: 2] = 2'(mb[r][c]);
    return v;
  endfunction

  always @(negedge clk) begin
    int h, exp_ready;
    if (!rst_n) begin
      model_reset();
      idle_from = cyc;
    end else if (ev_kind == 1 && cyc == ev_cyc) begin
      mb[ev_row][ev_col] = mcur;
      mlr = ev_row; mlc = ev_col; mlp = mcur;
      if (mcnt < ROWS*COLS) mcnt++;
    end
    exp_ready = (!mover && cyc >= idle_from) ? 1 : 0;

    chk("mon_board",        bus.board,         exp_board());
    chk("mon_last_row",     bus.last_move_row, mlr);
    chk("mon_last_col",     bus.last_move_col, mlc);
    chk("mon_last_player",  bus.last_player,   mlp);
    chk("mon_cur_player",   bus.cur_player,    mcur);
    chk("mon_game_over",    bus.game_over,     mover);
    chk("mon_winner",       bus.winner,        mwin);
    chk("mon_move_ready",   bus.move_ready,    exp_ready);
    chk("mon_move_done",    bus.move_done,     (rst_n && ev_kind == 1 && cyc == ev_cyc) ? 1 : 0);
    chk("mon_move_invalid", bus.move_invalid,  (rst_n && ev_kind == 2 && cyc == ev_cyc) ? 1 : 0);

    if (rst_n) begin
      if (ev_kind != 0 && cyc == ev_cyc) begin
        if (ev_kind == 1) begin
          if (bus.win_in) begin mover = 1; mwin = mlp; end
          else if (mcnt == ROWS*COLS) begin mover = 1; mwin = 0; end
          else mcur = 3 - mcur;
        end
        ev_kind = 0;
      end
      if (bus.new_game) begin
        model_reset();
        idle_from = cyc + 1;
      end else if (bus.move_valid && exp_ready != 0) begin
        if (bus.move_col >= 3'(COLS)) begin
          ev_kind = 2; ev_cyc = cyc + 1;
        end else begin
          h = 0;
          for (int r = 0; r < ROWS; r++) if (mb[r][bus.move_col] != 0) h++;
          if (h == ROWS) begin
            ev_kind = 2; ev_cyc = cyc + (FAST ? 2 : ROWS + 1);
          end else begin
            ev_kind = 1; ev_row = ROWS - 1 - h; ev_col = int'(bus.move_col);
            ev_cyc = cyc + (FAST ? 3 : 3 + h);
          end
        end
        idle_from = ev_cyc + 1;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk); #1;
    bus.win_in = 1'b0; bus.new_game = 1'b0; bus.move_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_new_game();
    @(posedge clk); #1;
    bus.new_game = 1'b1; bus.move_valid = 1'b0; bus.win_in = 1'b0;
    @(posedge clk); #1;
    bus.new_game = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_move(input int col, input bit win, output int lat, output bit inv);
    int t0;
    bit hs;
    @(posedge clk); #1;
    bus.move_valid = 1'b1; bus.move_col = 3'(col); bus.win_in = win; bus.new_game = 1'b0;
    @(negedge clk);
    hs = bus.move_ready; t0 = cyc;
    @(posedge clk); #1;
    bus.move_valid = 1'b0;
    lat = -1; inv = 1'b0;
    if (hs) begin
      for (int i = 0; i < ROWS + 8; i++) begin
        @(negedge clk);
        if (bus.move_done || bus.move_invalid) begin
          lat = cyc - t0; inv = bus.move_invalid;
          break;
        end
      end
      if (lat < 0) chk("move_timeout", 0, 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ndone, pulses;
    bit inv;
    int over_cnt;
    bus.new_game = 1'b0; bus.move_valid = 1'b0; bus.move_col = '0; bus.win_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_board",      bus.board, '0);
    chk("reset_cur_player", bus.cur_player, 2'b01);
    chk("reset_ready",      bus.move_ready, 1'b1);
    chk("reset_game_over",  bus.game_over, 1'b0);

    // 1: first drop lands at the bottom row
    do_move(3, 1'b0, lat, inv);
    chk("t1_latency",     lat, 3);
    chk("t1_cell_5_3",    bus.board[5][3], 2'b01);
    chk("t1_last_row",    bus.last_move_row, 3'd5);
    chk("t1_last_col",    bus.last_move_col, 3'd3);
    chk("t1_last_player", bus.last_player, 2'b01);
    step();
    chk("t1_cur_player",  bus.cur_player, 2'b10);

    // 2: fifth piece in one column
    start_new_game();
    for (int i = 0; i < 4; i++) do_move(3, 1'b0, lat, inv);
    do_move(3, 1'b0, lat, inv);
    chk("t2_latency",  lat, FAST ? 3 : 7);
    chk("t2_cell_1_3", bus.board[1][3], 2'b01);
    chk("t2_last_row", bus.last_move_row, 3'd1);
    step();
    chk("t2_cur_player", bus.cur_player, 2'b10);

    // 3: full column and out-of-range column
    start_new_game();
    for (int i = 0; i < ROWS; i++) do_move(0, 1'b0, lat, inv);
    do_move(0, 1'b0, lat, inv);
    chk("t3_full_invalid", inv, 1'b1);
    chk("t3_full_latency", lat, FAST ? 2 : ROWS + 1);
    step();
    chk("t3_cur_player", bus.cur_player, 2'b01);
    chk("t3_cell_0_0",   bus.board[0][0], 2'b10);
    do_move(7, 1'b0, lat, inv);
    chk("t3_oor_invalid", inv, 1'b1);
    chk("t3_oor_latency", lat, 1);

    // 4: P1 wins along the bottom row
    start_new_game();
    for (int i = 0; i < 3; i++) begin
      do_move(i, 1'b0, lat, inv);
      do_move(i, 1'b0, lat, inv);
    end
    do_move(3, 1'b1, lat, inv);
    step();
    chk("t4_game_over", bus.game_over, 1'b1);
    chk("t4_winner",    bus.winner, 2'b01);
    chk("t4_ready",     bus.move_ready, 1'b0);
    do_move(4, 1'b0, lat, inv);
    chk("t4_ignored",   lat, -1);
    chk("t4_cell_5_4",  bus.board[5][4], 2'b00);

    // 5: full board with no win is a draw
    start_new_game();
    ndone = 0;
    for (int i = 0; i < ROWS*COLS; i++) begin
      do_move(i % COLS, 1'b0, lat, inv);
      if (lat > 0 && !inv) ndone++;
    end
    chk("t5_done_count", ndone, ROWS*COLS);
    step();
    chk("t5_game_over", bus.game_over, 1'b1);
    chk("t5_winner",    bus.winner, 2'b00);

    // 6a: new_game during the scan of a 4-high column
    start_new_game();
    for (int i = 0; i < 4; i++) do_move(2, 1'b0, lat, inv);
    @(posedge clk); #1;
    bus.move_valid = 1'b1; bus.move_col = 3'd2;
    @(negedge clk);
    @(posedge clk); #1;
    bus.move_valid = 1'b0; bus.new_game = 1'b1;
    @(posedge clk); #1;
    bus.new_game = 1'b0;
    @(negedge clk);
    chk("t6_ready", bus.move_ready, 1'b1);
    chk("t6_board", bus.board, '0);
    chk("t6_cur",   bus.cur_player, 2'b01);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.move_done || bus.move_invalid) pulses++;
      step();
    end
    chk("t6_no_pulses", pulses, 0);

    // 6b: asynchronous reset in the middle of PLACE
    do_move(0, 1'b0, lat, inv);
    @(posedge clk); #1;
    bus.move_valid = 1'b1; bus.move_col = 3'd1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.move_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_board",       bus.board, '0);
    chk("t6_rst_cur",         bus.cur_player, 2'b01);
    chk("t6_rst_last_player", bus.last_player, 2'b00);
    @(negedge clk); #1;
    rst_n = 1'b1;

    // randomized play
    start_new_game();
    over_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      bus.move_valid = ($urandom_range(0, 3) != 0);
      bus.move_col   = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
      bus.win_in     = ($urandom_range(0, 29) == 0);
      over_cnt       = bus.game_over ? over_cnt + 1 : 0;
      bus.new_game   = (over_cnt >= 3) || ($urandom_range(0, 199) == 0);
    end
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
